game_logic: RTL and testbench
=============================

# game_logic

Per-frame game-state engine for Breakout. Consumes the one-cycle `FRAME_DONE` pulse that the renderer emits at the start of vertical blank. On each pulse it advances paddle, ball, lives and the game-phase state machine. Drives `PADDLE_X_PIXEL`, `BALL_X_PIXEL` and `BALL_Y_PIXEL` back into the renderer, so all positions are stable while the next visible frame is scanned.

## Interface
Parameters:
- `PADDLE_SPEED`, 4: paddle pixels moved per frame while a direction button is held.
- `BALL_SPEED`, 2: ball pixels moved per frame on each axis. Legal range is 1..7.
- `LOST_FRAMES`, 60: frames spent in LOST before the next serve.
- `START_LIVES`, 3: lives after reset and after a restart.

Ports:
- `CLK` in 1: pixel clock, the same clock that drives the renderer.
- `RESET_N` in 1: asynchronous, active-low reset.
- `FRAME_DONE` in 1: one-cycle pulse per frame, synchronous to `CLK`.
- `BTN_LEFT`, `BTN_RIGHT`, `BTN_SERVE` in 1 each: raw asynchronous buttons, active high.
- `PADDLE_X_PIXEL` out 10: paddle left edge.
- `BALL_X_PIXEL`, `BALL_Y_PIXEL` out 10: ball top-left corner.
- `LIVES` out 2: remaining lives.
- `BALL_LOST` out 1: one-cycle pulse when a ball is lost.
- `GAME_OVER` out 1: high while in the GAME_OVER state.

## Operation
Derived geometry (pixels):
- Play area x runs from 8 to 791.
- Ball x range: `XMIN`=8, `XMAX`=784.
- Ceiling bottom: `YMIN`=24.
- Paddle top: 576. Ball rest y: `YPAD`=568.
- Paddle x range: 8..728. Paddle length 64. Ball size 8.

Phase state machine: SERVE, PLAY, LOST, GAME_OVER. Everything below is evaluated only on a `FRAME_DONE` cycle. It uses synchronized button levels.

Paddle, updated in every state except GAME_OVER:
- Left only: x = max(8, x − `PADDLE_SPEED`).
- Right only: x = min(728, x + `PADDLE_SPEED`).
- Both or neither: no change.

SERVE:
- Ball is parked at x = new paddle x + 28, y = 568.
- If `BTN_SERVE` is high: go to PLAY with dx=+1 and dy=−1 (up). The ball does not move on this frame.

PLAY: x and y are updated independently, each with speed s = `BALL_SPEED`.
- Moving left, x − s ≤ 8: x=8, dx=+1. Otherwise x −= s.
- Moving right, x + s ≥ 784: x=784, dx=−1. Otherwise x += s.
- Moving up, y − s ≤ 24: y=24, dy=+1. Otherwise y −= s.
- Moving down, paddle catch: all three conditions hold:
  - current y ≤ 568;
  - y + s ≥ 568;
  - the ball overlaps the paddle, i.e. new ball x + 8 > new paddle x and new ball x < new paddle x + 64.

  Result: y=568, dy=−1.
- Moving down, no catch and y + s ≥ 600: the ball is lost.
  - `BALL_LOST` pulses and y=600 (off-screen).
  - `LIVES` decrements.
  - If `LIVES` was 1, go to GAME_OVER. Otherwise go to LOST and clear the frame counter.
- Moving down, otherwise: y += s.
- A corner hit reflects both axes on the same frame.

LOST:
- Ball is held at y=600.
- The counter increments each frame. When it reaches `LOST_FRAMES` − 1, go to SERVE.

GAME_OVER:
- Ball is held at y=600. The paddle is frozen.
- `BTN_SERVE` sets `LIVES` = `START_LIVES` and goes to SERVE.

## Timing
- Reset values: PADDLE_X=368, BALL_X=396, BALL_Y=568, `LIVES`=`START_LIVES`, state SERVE, `BALL_LOST`=0, `GAME_OVER`=0.
- `RESET_N` low forces all of the above immediately, including mid-frame or mid-LOST.
- Buttons pass through 2-flop synchronizers. A press must be stable for ≥2 `CLK` cycles before `FRAME_DONE` to be seen that frame.
- All outputs are registered and change on the `CLK` edge that samples `FRAME_DONE`=1. They are visible the following cycle and are held constant until the next pulse.
- `BALL_LOST` is high for exactly that one cycle.
- Back-to-back `FRAME_DONE` pulses are legal; each one is a full update.
- Arithmetic is done 11-bit internally. Clamps guarantee the 10-bit outputs never wrap.

## Structure
- Pixel-derived bounds (XMIN, XMAX, YMIN, YPAD, paddle limits, paddle reset x) go into the shared geometry include, next to the existing tile constants. They are computed from those constants and never hard-coded.
- State encodings live in the same include.
- One sub-module, `button_sync`: a 2-flop synchronizer parameterized by width and instantiated with width 3.

## Test plan
- Reset, then hold `BTN_SERVE` across a pulse: state PLAY, ball still (396,568). Next pulse: ball (398,566).
- PLAY with ball at y=25 moving up: after one pulse y=24 and dy down. Next pulse y=26.
- Ball x=783 moving right, y=100 moving up: x=784 with dx left, y=98.
- Ball y=566 moving down, x=400, paddle x=368: y=568, dy up. Repeat with paddle x=8: ball continues downward, and the pulse with y=598 → `BALL_LOST` pulse, `LIVES` 3→2, y=600. SERVE is entered after exactly 60 further pulses.
- `LIVES`=1 and the ball is lost: `LIVES`=0, `GAME_OVER`=1, and held left/right buttons leave the paddle unchanged. `BTN_SERVE` then gives `LIVES`=3 and SERVE.
- Paddle at x=10 with left held: 8, then 8. Both buttons held: no change. Assert `RESET_N` low mid-LOST: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/game_logic_pkg.sv
// Shared screen geometry and game-phase encodings for the Breakout engine.
// Latency: n/a (constants, types and one pure helper function).
// Backpressure: n/a.
package game_logic_pkg;

    // Tile grid shared with the renderer; every pixel bound below derives from it
    localparam int TILE_PX        = 8;
    localparam int SCREEN_W_TILES = 100;
    localparam int SCREEN_H_TILES = 75;
    localparam int WALL_TILES     = 1;   // side walls, one tile thick
    localparam int CEIL_TILES     = 3;   // score bar plus ceiling
    localparam int PADDLE_ROW     = 72;  // tile row holding the paddle top edge
    localparam int PADDLE_TILES   = 8;
    localparam int BALL_TILES     = 1;

    localparam int SCREEN_W_PX = SCREEN_W_TILES * TILE_PX;
    localparam int SCREEN_H_PX = SCREEN_H_TILES * TILE_PX;
    localparam int WALL_PX     = WALL_TILES * TILE_PX;
    localparam int BALL_PX     = BALL_TILES * TILE_PX;
    localparam int PADDLE_PX   = PADDLE_TILES * TILE_PX;

    // Pixel bounds, held at the 11-bit internal arithmetic width
    localparam logic [10:0] BALL_SIZE   = 11'(BALL_PX);
    localparam logic [10:0] PADDLE_LEN  = 11'(PADDLE_PX);
    localparam logic [10:0] XMIN        = 11'(WALL_PX);
    localparam logic [10:0] XMAX        = 11'(SCREEN_W_PX - WALL_PX - BALL_PX);
    localparam logic [10:0] YMIN        = 11'(CEIL_TILES * TILE_PX);
    localparam logic [10:0] PADDLE_Y    = 11'(PADDLE_ROW * TILE_PX);
    localparam logic [10:0] YPAD        = 11'(PADDLE_ROW * TILE_PX - BALL_PX);
    localparam logic [10:0] YLOST       = 11'(SCREEN_H_PX);
    localparam logic [10:0] PADDLE_XMIN = 11'(WALL_PX);
    localparam logic [10:0] PADDLE_XMAX = 11'(SCREEN_W_PX - WALL_PX - PADDLE_PX);
    localparam logic [10:0] PADDLE_XRST = 11'((SCREEN_W_PX - PADDLE_PX) / 2);
    localparam logic [10:0] SERVE_OFS   = 11'((PADDLE_PX - BALL_PX) / 2);
    localparam logic [10:0] BALL_XRST   = 11'((SCREEN_W_PX - PADDLE_PX) / 2 + (PADDLE_PX - BALL_PX) / 2);

    // Game phase encodings
    typedef enum logic [1:0] {
        PH_SERVE     = 2'd0,
        PH_PLAY      = 2'd1,
        PH_LOST      = 2'd2,
        PH_GAME_OVER = 2'd3
    } phase_t;

    // True when the ball's horizontal span overlaps the paddle's span
    function automatic logic ball_over_paddle(input logic [10:0] bx, input logic [10:0] px);
        return ((bx + BALL_SIZE) > px) && (bx < (px + PADDLE_LEN));
    endfunction

endpackage

// File: rtl/game_logic_button_sync.sv
// Two-flop synchronizer bringing raw asynchronous button levels into CLK.
// Latency: 2 CLK cycles from a stable input to the synchronized output.
// Backpressure: none; free-running level sampler.
module button_sync #(
    parameter int WIDTH = 3
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] btn_async,
    output logic [WIDTH-1:0] btn_sync
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives it a full cycle to settle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            meta     <= '0;
            btn_sync <= '0;
        end else begin
            meta     <= btn_async;
            btn_sync <= meta;
        end
    end

endmodule

// File: rtl/game_logic.sv
// Per-frame Breakout state engine: paddle, ball, lives and game phase.
// Latency: outputs update on the CLK edge sampling FRAME_DONE, held until the next pulse.
// Backpressure: none; every FRAME_DONE pulse, including back-to-back ones, is a full update.
module game_logic
    import game_logic_pkg::*;
#(
    parameter int PADDLE_SPEED = 4,
    parameter int BALL_SPEED   = 2,
    parameter int LOST_FRAMES  = 60,
    parameter int START_LIVES  = 3
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       FRAME_DONE,
    input  logic       BTN_LEFT,
    input  logic       BTN_RIGHT,
    input  logic       BTN_SERVE,
    output logic [9:0] PADDLE_X_PIXEL,
    output logic [9:0] BALL_X_PIXEL,
    output logic [9:0] BALL_Y_PIXEL,
    output logic [1:0] LIVES,
    output logic       BALL_LOST,
    output logic       GAME_OVER
);

    localparam int CNT_W = (LOST_FRAMES > 1) ? $clog2(LOST_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_FRAMES - 1);
    localparam logic [10:0]      PAD_STEP   = 11'(PADDLE_SPEED);
    localparam logic [10:0]      BALL_STEP  = 11'(BALL_SPEED);
    localparam logic [1:0]       LIVES_INIT = 2'(START_LIVES);

    logic [2:0] btn_q;
    logic       btn_left;
    logic       btn_right;
    logic       btn_serve;

    // Registered game state; positions kept 11 bits wide so arithmetic never wraps
    phase_t           phase;
    logic [10:0]      paddle_x;
    logic [10:0]      ball_x;
    logic [10:0]      ball_y;
    logic             dx_right;
    logic             dy_up;
    logic [1:0]       lives;
    logic [CNT_W-1:0] lost_cnt;
    logic             ball_lost_q;
    logic             game_over_q;

    // Candidate next values for the current frame
    logic [10:0] pad_nx;
    logic [10:0] serve_x;
    logic [10:0] bx_nx;
    logic [10:0] by_nx;
    logic        dx_nx;
    logic        dy_nx;
    logic        miss;

    button_sync #(
        .WIDTH(3)
    ) u_button_sync (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .btn_async({BTN_SERVE, BTN_RIGHT, BTN_LEFT}),
        .btn_sync (btn_q)
    );

    assign btn_left  = btn_q[0];
    assign btn_right = btn_q[1];
    assign btn_serve = btn_q[2];

    // Paddle move for this frame: one direction only, clamped to the play area
    always_comb begin
        pad_nx = paddle_x;
        if (btn_left && !btn_right) begin
            if (paddle_x <= (PADDLE_XMIN + PAD_STEP)) begin
                pad_nx = PADDLE_XMIN;
            end else begin
                pad_nx = paddle_x - PAD_STEP;
            end
        end else if (btn_right && !btn_left) begin
            if ((paddle_x + PAD_STEP) >= PADDLE_XMAX) begin
                pad_nx = PADDLE_XMAX;
            end else begin
                pad_nx = paddle_x + PAD_STEP;
            end
        end
    end

    assign serve_x = pad_nx + SERVE_OFS;

    // Ball step for PLAY: axes independent, walls reflect, paddle catch uses new x positions
    always_comb begin
        bx_nx = ball_x;
        by_nx = ball_y;
        dx_nx = dx_right;
        dy_nx = dy_up;
        miss  = 1'b0;

        if (dx_right) begin
            if ((ball_x + BALL_STEP) >= XMAX) begin
                bx_nx = XMAX;
                dx_nx = 1'b0;
            end else begin
                bx_nx = ball_x + BALL_STEP;
            end
        end else begin
            if (ball_x <= (XMIN + BALL_STEP)) begin
                bx_nx = XMIN;
                dx_nx = 1'b1;
            end else begin
                bx_nx = ball_x - BALL_STEP;
            end
        end

        if (dy_up) begin
            if (ball_y <= (YMIN + BALL_STEP)) begin
                by_nx = YMIN;
                dy_nx = 1'b0;
            end else begin
                by_nx = ball_y - BALL_STEP;
            end
        end else begin
            if ((ball_y <= YPAD) && ((ball_y + BALL_STEP) >= YPAD) &&
                ball_over_paddle(bx_nx, pad_nx)) begin
                by_nx = YPAD;
                dy_nx = 1'b1;
            end else if ((ball_y + BALL_STEP) >= YLOST) begin
                by_nx = YLOST;
                miss  = 1'b1;
            end else begin
                by_nx = ball_y + BALL_STEP;
            end
        end
    end

    // Phase machine and all registered outputs, advanced once per FRAME_DONE
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            phase       <= PH_SERVE;
            paddle_x    <= PADDLE_XRST;
            ball_x      <= BALL_XRST;
            ball_y      <= YPAD;
            dx_right    <= 1'b1;
            dy_up       <= 1'b1;
            lives       <= LIVES_INIT;
            lost_cnt    <= '0;
            ball_lost_q <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            ball_lost_q <= 1'b0;
            if (FRAME_DONE) begin
                case (phase)
                    PH_SERVE: begin
                        paddle_x <= pad_nx;
                        ball_x   <= serve_x;
                        ball_y   <= YPAD;
                        if (btn_serve) begin
                            phase    <= PH_PLAY;
                            dx_right <= 1'b1;
                            dy_up    <= 1'b1;
                        end
                    end
                    PH_PLAY: begin
                        paddle_x <= pad_nx;
                        ball_x   <= bx_nx;
                        ball_y   <= by_nx;
                        dx_right <= dx_nx;
                        dy_up    <= dy_nx;
                        if (miss) begin
                            ball_lost_q <= 1'b1;
                            lives       <= lives - 2'd1;
                            if (lives == 2'd1) begin
                                phase       <= PH_GAME_OVER;
                                game_over_q <= 1'b1;
                            end else begin
                                phase    <= PH_LOST;
                                lost_cnt <= '0;
                            end
                        end
                    end
                    PH_LOST: begin
                        paddle_x <= pad_nx;
                        ball_y   <= YLOST;
                        if (lost_cnt == LOST_LAST) begin
                            phase <= PH_SERVE;
                        end else begin
                            lost_cnt <= lost_cnt + CNT_W'(1);
                        end
                    end
                    PH_GAME_OVER: begin
                        ball_y <= YLOST;
                        if (btn_serve) begin
                            lives       <= LIVES_INIT;
                            phase       <= PH_SERVE;
                            game_over_q <= 1'b0;
                        end
                    end
                    default: begin
                        phase <= PH_SERVE;
                    end
                endcase
            end
        end
    end

    assign PADDLE_X_PIXEL = paddle_x[9:0];
    assign BALL_X_PIXEL   = ball_x[9:0];
    assign BALL_Y_PIXEL   = ball_y[9:0];
    assign LIVES          = lives;
    assign BALL_LOST      = ball_lost_q;
    assign GAME_OVER      = game_over_q;

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic with a reference model feeding a scoreboard.
// Latency: expected outputs are compared at the negedge after each FRAME_DONE edge.
// Backpressure: n/a.
module tb_game_logic;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       FRAME_DONE;
    logic       BTN_LEFT;
    logic       BTN_RIGHT;
    logic       BTN_SERVE;
    logic [9:0] PADDLE_X_PIXEL;
    logic [9:0] BALL_X_PIXEL;
    logic [9:0] BALL_Y_PIXEL;
    logic [1:0] LIVES;
    logic       BALL_LOST;
    logic       GAME_OVER;

    typedef struct packed {
        logic [9:0] px;
        logic [9:0] bx;
        logic [9:0] by;
        logic [1:0] lives;
        logic       lost;
        logic       go;
    } obs_t;

    obs_t dut_obs;
    obs_t sb[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    // Reference model state (plain integers, numbers taken from the game rules)
    int m_px, m_bx, m_by, m_lives, m_state, m_cnt;
    bit m_dxr, m_dyu, m_lost;
    bit b_l, b_r, b_s;

    game_logic u_dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .FRAME_DONE    (FRAME_DONE),
        .BTN_LEFT      (BTN_LEFT),
        .BTN_RIGHT     (BTN_RIGHT),
        .BTN_SERVE     (BTN_SERVE),
        .PADDLE_X_PIXEL(PADDLE_X_PIXEL),
        .BALL_X_PIXEL  (BALL_X_PIXEL),
        .BALL_Y_PIXEL  (BALL_Y_PIXEL),
        .LIVES         (LIVES),
        .BALL_LOST     (BALL_LOST),
        .GAME_OVER     (GAME_OVER)
    );

    always #5 CLK = ~CLK;

    assign dut_obs = {PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, LIVES, BALL_LOST, GAME_OVER};

    function automatic obs_t model_obs();
        obs_t o;
        o.px    = 10'(m_px);
        o.bx    = 10'(m_bx);
        o.by    = 10'(m_by);
        o.lives = 2'(m_lives);
        o.lost  = m_lost;
        o.go    = (m_state == 3);
        return o;
    endfunction

    task automatic model_reset();
        m_px = 368; m_bx = 396; m_by = 568; m_lives = 3;
        m_state = 0; m_cnt = 0; m_dxr = 1'b1; m_dyu = 1'b1; m_lost = 1'b0;
    endtask

    // One frame of game rules: 0=SERVE 1=PLAY 2=LOST 3=GAME_OVER
    task automatic model_step(input bit l, input bit r, input bit s);
        int np;
        np = m_px;
        m_lost = 1'b0;
        if (l && !r) np = (m_px - 4 < 8) ? 8 : m_px - 4;
        if (r && !l) np = (m_px + 4 > 728) ? 728 : m_px + 4;
        case (m_state)
            0: begin
                m_px = np; m_bx = np + 28; m_by = 568;
                if (s) begin m_state = 1; m_dxr = 1'b1; m_dyu = 1'b1; end
            end
            1: begin
                m_px = np;
                if (m_dxr) begin
                    if (m_bx + 2 >= 784) begin m_bx = 784; m_dxr = 1'b0; end
                    else m_bx = m_bx + 2;
                end else begin
                    if (m_bx - 2 <= 8) begin m_bx = 8; m_dxr = 1'b1; end
                    else m_bx = m_bx - 2;
                end
                if (m_dyu) begin
                    if (m_by - 2 <= 24) begin m_by = 24; m_dyu = 1'b0; end
                    else m_by = m_by - 2;
                end else if (m_by <= 568 && m_by + 2 >= 568 && m_bx + 8 > np && m_bx < np + 64) begin
                    m_by = 568; m_dyu = 1'b1;
                end else if (m_by + 2 >= 600) begin
                    m_by = 600; m_lost = 1'b1;
                    if (m_lives == 1) m_state = 3;
                    else begin m_state = 2; m_cnt = 0; end
                    m_lives = m_lives - 1;
                end else begin
                    m_by = m_by + 2;
                end
            end
            2: begin
                m_px = np; m_by = 600;
                if (m_cnt == 59) m_state = 0;
                else m_cnt = m_cnt + 1;
            end
            default: begin
                m_by = 600;
                if (s) begin m_lives = 3; m_state = 0; end
            end
        endcase
    endtask

    task automatic check(input string tag, input obs_t obs, input obs_t exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: got px=%0d bx=%0d by=%0d lives=%0d lost=%0b go=%0b, want px=%0d bx=%0d by=%0d lives=%0d lost=%0b go=%0b",
                   tag, obs.px, obs.bx, obs.by, obs.lives, obs.lost, obs.go,
                   exp.px, exp.bx, exp.by, exp.lives, exp.lost, exp.go);
        end
    endtask

    task automatic chk(input string tag, input int got, input int want);
        vec_cnt++;
        assert (got === want) else begin
            err_cnt++;
            $error("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    // Pulse FRAME_DONE for one edge; expected result queued now, compared once visible
    task automatic pulse();
        obs_t e;
        FRAME_DONE = 1'b1;
        model_step(b_l, b_r, b_s);
        sb.push_back(model_obs());
        @(negedge CLK);
        FRAME_DONE = 1'b0;
        e = sb.pop_front();
        check("frame", dut_obs, e);
    endtask

    // Set buttons, confirm outputs hold and BALL_LOST is back low, then pulse
    task automatic frame(input bit l, input bit r, input bit s);
        obs_t h;
        b_l = l; b_r = r; b_s = s;
        BTN_LEFT = l; BTN_RIGHT = r; BTN_SERVE = s;
        @(negedge CLK);
        h = model_obs();
        h.lost = 1'b0;
        check("hold", dut_obs, h);
        @(negedge CLK);
        pulse();
    endtask

    // Steer the paddle under the ball
    task automatic track_frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame(m_px > m_bx - 26, m_px < m_bx - 30, 1'b0);
        end
    endtask

    // Steer the paddle away from the ball until a ball is lost
    task automatic play_until_lost();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            frame(m_bx > 400, m_bx <= 400, 1'b0);
            seen = m_lost;
        end
        chk("ball_lost_within_budget", int'(seen), 1);
    endtask

    // Full LOST interval: 60 pulses at y=600, then the SERVE park
    task automatic lost_interval();
        for (int i = 0; i < 60; i++) frame(1'b0, 1'b1, 1'b0);
        chk("lost_y_after_60", int'(BALL_Y_PIXEL), 600);
        frame(1'b0, 1'b0, 1'b0);
        chk("serve_park_y", int'(BALL_Y_PIXEL), 568);
    endtask

    initial begin
        obs_t rst_exp;
        int   k;
        rst_exp = {10'd368, 10'd396, 10'd568, 2'd3, 1'b0, 1'b0};
        RESET_N = 1'b0; FRAME_DONE = 1'b0;
        BTN_LEFT = 1'b0; BTN_RIGHT = 1'b0; BTN_SERVE = 1'b0;
        b_l = 1'b0; b_r = 1'b0; b_s = 1'b0;
        model_reset();
        #23;
        check("reset", dut_obs, rst_exp);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Paddle clamps on both sides, both buttons hold still
        for (int i = 0; i < 95; i++) frame(1'b1, 1'b0, 1'b0);
        chk("paddle_left_clamp", int'(PADDLE_X_PIXEL), 8);
        frame(1'b1, 1'b1, 1'b0);
        chk("paddle_both_held", int'(PADDLE_X_PIXEL), 8);
        for (int i = 0; i < 185; i++) frame(1'b0, 1'b1, 1'b0);
        chk("paddle_right_clamp", int'(PADDLE_X_PIXEL), 728);
        for (int i = 0; i < 90; i++) frame(1'b1, 1'b0, 1'b0);
        chk("paddle_back_center", int'(PADDLE_X_PIXEL), 368);

        // Serve: ball still on the serve frame, then moves up-right
        frame(1'b0, 1'b0, 1'b1);
        chk("serve_x", int'(BALL_X_PIXEL), 396);
        chk("serve_y", int'(BALL_Y_PIXEL), 568);
        frame(1'b0, 1'b0, 1'b0);
        chk("first_move_x", int'(BALL_X_PIXEL), 398);
        chk("first_move_y", int'(BALL_Y_PIXEL), 566);

        // Rise to the ceiling: right wall at frame 194, ceiling at 272; some back-to-back pulses
        k = 1;
        while (k < 273) begin
            if (k >= 100 && k < 110) pulse();
            else frame(1'b0, 1'b0, 1'b0);
            k++;
            if (k == 194) begin
                chk("right_wall_x", int'(BALL_X_PIXEL), 784);
                chk("right_wall_y", int'(BALL_Y_PIXEL), 180);
            end
            if (k == 195) chk("after_wall_x", int'(BALL_X_PIXEL), 782);
            if (k == 272) begin
                chk("ceiling_x", int'(BALL_X_PIXEL), 628);
                chk("ceiling_y", int'(BALL_Y_PIXEL), 24);
            end
        end
        chk("after_ceiling_y", int'(BALL_Y_PIXEL), 26);

        // Descend onto the tracking paddle, then lose the first ball
        track_frames(400);
        play_until_lost();
        chk("lives_after_first_loss", int'(LIVES), 2);
        chk("lost_y", int'(BALL_Y_PIXEL), 600);
        lost_interval();

        frame(1'b0, 1'b0, 1'b1);
        play_until_lost();
        chk("lives_after_second_loss", int'(LIVES), 1);
        lost_interval();

        // Last life: game over freezes the paddle, serve restarts
        frame(1'b0, 1'b0, 1'b1);
        play_until_lost();
        chk("lives_at_game_over", int'(LIVES), 0);
        chk("game_over_flag", int'(GAME_OVER), 1);
        for (int i = 0; i < 4; i++) frame(1'b1, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b1);
        chk("lives_restart", int'(LIVES), 3);
        chk("game_over_cleared", int'(GAME_OVER), 0);
        frame(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of LOST
        frame(1'b0, 1'b0, 1'b1);
        play_until_lost();
        for (int i = 0; i < 20; i++) frame(1'b0, 1'b0, 1'b0);
        #3 RESET_N = 1'b0;
        #1 check("async_reset_mid_lost", dut_obs, rst_exp);
        @(negedge CLK);
        RESET_N = 1'b1;
        model_reset();
        frame(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
